// File: rtl/rsdec_syn_par.sv
// Reed-Solomon syndrome calculator: Horner accumulation of NSYN syndromes in parallel,
// followed by sequential readout of S_0..S_(NSYN-1) over a valid/ready handshake.
module rsdec_syn_par #(
    parameter int unsigned M    = 8,
    parameter logic [M:0]  POLY = 9'h11D,
    parameter int unsigned NSYN = 16,
    parameter int unsigned FCR  = 1,
    parameter int unsigned N    = 255
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sof,
    input  logic [M-1:0]            in_data,
    output logic                    syn_valid,
    input  logic                    syn_ready,
    output logic [M-1:0]            syn_data,
    output logic [$clog2(NSYN)-1:0] syn_idx,
    output logic                    syn_last,
    output logic                    zero_flag,
    output logic                    seq_err
);

    localparam int unsigned IdxW = $clog2(NSYN);
    localparam int unsigned CntW = $clog2(N + 1);

    function automatic logic [M-1:0] gf_xtime(input logic [M-1:0] v);
        return {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY[M-1:0] : '0);
    endfunction

    function automatic logic [M-1:0] gf_pow(input int unsigned k);
        logic [M-1:0] p;
        p = {{(M-1){1'b0}}, 1'b1};
        for (int unsigned j = 0; j < k; j++) p = gf_xtime(p);
        return p;
    endfunction

    // With c constant this folds into a fixed XOR network.
    function automatic logic [M-1:0] gf_mul_const(input logic [M-1:0] a,
                                                  input logic [M-1:0] c);
        logic [M-1:0] acc;
        logic [M-1:0] p;
        acc = '0;
        p   = c;
        for (int unsigned j = 0; j < M; j++) begin
            if (a[j]) acc = acc ^ p;
            p = gf_xtime(p);
        end
        return acc;
    endfunction

    typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

    state_e            state_q, state_d;
    logic [M-1:0]      s_q   [NSYN];
    logic [M-1:0]      s_d   [NSYN];
    logic [M-1:0]      s_upd [NSYN];
    logic [CntW-1:0]   count_q, count_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              zero_q, zero_d;
    logic              seq_err_q, seq_err_d;
    logic              in_fire, out_fire, last_sym, upd_nz;

    for (genvar g = 0; g < NSYN; g++) begin : g_mul
        localparam logic [M-1:0] Coef = gf_pow(FCR + g);
        assign s_upd[g] = gf_mul_const(s_q[g], Coef) ^ in_data;
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = syn_valid & syn_ready;
    assign last_sym = (count_q == CntW'(N - 1));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_fire && in_sof) state_d = StAcc;
            StAcc:   if (in_fire && !in_sof && last_sym) state_d = StOut;
            StOut:   if (out_fire && syn_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = !clr && (state_q != StOut);
        syn_valid = (state_q == StOut);
        syn_last  = syn_valid && (idx_q == IdxW'(NSYN - 1));
        zero_flag = syn_valid && zero_q;
        syn_data  = s_q[idx_q];
        syn_idx   = idx_q;
        seq_err   = seq_err_q;
    end

    always_comb begin
        upd_nz = 1'b0;
        for (int i = 0; i < NSYN; i++) upd_nz = upd_nz | (|s_upd[i]);
    end

    always_comb begin
        s_d       = s_q;
        count_d   = count_q;
        idx_d     = idx_q;
        zero_d    = zero_q;
        seq_err_d = 1'b0;
        if (in_fire) begin
            if (in_sof) begin
                for (int i = 0; i < NSYN; i++) s_d[i] = in_data;
                count_d   = CntW'(1);
                seq_err_d = (state_q == StAcc);
            end else if (state_q == StIdle) begin
                seq_err_d = 1'b1;
            end else begin
                s_d     = s_upd;
                count_d = count_q + CntW'(1);
                if (last_sym) begin
                    zero_d = !upd_nz;
                    idx_d  = '0;
                end
            end
        end
        if (out_fire) idx_d = syn_last ? '0 : idx_q + IdxW'(1);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NSYN; i++) s_q[i] <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            zero_q    <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            s_q       <= s_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            zero_q    <= zero_d;
            seq_err_q <= seq_err_d;
        end
    end

endmodule

// File: doc/rsdec_syn_par.md
RSDEC_SYN_PAR -- requirements
Module: rsdec_syn_par

Interface
REQ-001 SHALL have parameter M, default 8: symbol width in bits, GF(2^M).
REQ-002 SHALL have parameter POLY, default 9'h11D: field primitive polynomial, M+1 bits.
REQ-003 SHALL have parameter NSYN, default 16: number of syndromes (2t), range 2..64.
REQ-004 SHALL have parameter FCR, default 1: syndrome S_i is evaluated at alpha^(FCR+i), alpha = 2.
REQ-005 SHALL have parameter N, default 255: codeword length in symbols, range NSYN+1..2^M-1.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 SHALL have port clr, input, 1 bit: reset; asynchronous and active-high.
REQ-008 SHALL have port in_valid, input, 1 bit: in_data/in_sof are valid.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepts a symbol this cycle.
REQ-010 SHALL have port in_sof, input, 1 bit: symbol is the first (highest-degree) symbol of a codeword.
REQ-011 SHALL have port in_data, input, M bits: received symbol.
REQ-012 SHALL have port syn_valid, output, 1 bit: syn_data/syn_idx are valid.
REQ-013 SHALL have port syn_ready, input, 1 bit: downstream accepts a syndrome.
REQ-014 SHALL have port syn_data, output, M bits: syndrome S_syn_idx.
REQ-015 SHALL have port syn_idx, output, $clog2(NSYN) bits: syndrome index, 0 first.
REQ-016 SHALL have port syn_last, output, 1 bit: high with syn_valid when syn_idx = NSYN-1.
REQ-017 SHALL have port zero_flag, output, 1 bit: all NSYN syndromes of the frame are zero; valid while syn_valid is high.
REQ-018 SHALL have port seq_err, output, 1 bit: one-cycle pulse on a dropped symbol.

Function
REQ-019 SHALL define a transfer as in_valid&in_ready (input) or syn_valid&syn_ready (output) on a rising clk edge.
REQ-020 SHALL implement states IDLE, ACC, OUT; in_ready = 1 in IDLE/ACC, 0 in OUT; syn_valid = 1 only in OUT.
REQ-021 SHALL handle an IDLE transfer with in_sof=1 as: S_i <= in_data for all i; count <= 1; go to ACC.
REQ-022 SHALL handle an IDLE transfer with in_sof=0 as: symbol dropped; seq_err pulses the next cycle; stay in IDLE.
REQ-023 SHALL handle an ACC transfer with in_sof=0 as: S_i <= S_i*alpha^(FCR+i) XOR in_data in GF(2^M) mod POLY; count increments.
REQ-024 SHALL handle an ACC transfer with in_sof=1 as: abort the frame, re-initialise per REQ-021, and pulse seq_err.
REQ-025 SHALL, on the transfer that makes count = N, compute zero_flag = (all S_i = 0) on the updated values, clear the output index to 0, and go to OUT; syn_valid rises the next cycle.
REQ-026 SHALL, in OUT, present S_idx on syn_data; syn_data and syn_idx stay stable while syn_ready = 0.
REQ-027 SHALL, on each OUT transfer, increment the index; on the transfer with syn_last, return to IDLE, with in_ready high the following cycle.
REQ-028 SHALL derive the constant multipliers alpha^(FCR+i) at elaboration from M/POLY as XOR networks, with no runtime multiplier.
REQ-029 SHALL use a count register of width $clog2(N+1) that never wraps.
REQ-030 SHALL NOT change any S_i, count or state on a cycle without a transfer; in_data is ignored in OUT.

Reset
REQ-031 SHALL, while clr = 1, force state IDLE, all S_i = 0, count = 0, index = 0, syn_valid = 0, syn_last = 0, zero_flag = 0, seq_err = 0, in_ready = 0.
REQ-032 SHALL make in_ready = 1 in the first cycle after clr deasserts.
REQ-033 SHALL, on clr asserted mid-frame or mid-output, discard the frame and resume only via a new in_sof symbol.

Verification
REQ-034 SHALL cover: 255 zero symbols, sof on the first, defaults -> 16 syndromes 0x00, idx 0..15, zero_flag = 1, syn_last on idx 15.
REQ-035 SHALL cover: 254 zeros then last symbol 0x05 -> every S_i = 0x05, zero_flag = 0.
REQ-036 SHALL cover: first symbol 0x01 then 254 zeros -> S_0 = alpha^254 = 0x8E, S_i = alpha^(-(i+1)).
REQ-037 SHALL cover: syn_ready held low 3 cycles at idx 4 -> syn_data/syn_idx stable, no syndrome skipped or repeated.
REQ-038 SHALL cover: in_sof reasserted at symbol 100 followed by a full frame -> seq_err pulse, results equal those of the second frame alone.
REQ-039 SHALL cover: clr pulsed at idx 7 of OUT -> outputs per REQ-031; non-sof symbol -> seq_err; next frame correct.
